matrix_load_ctrl: RTL and testbench
===================================

MATRIX_LOAD_CTRL -- requirements
Module: matrix_load_ctrl

Interface
REQ-001 SHALL have parameter SIZE_A, default 8: matrix row count, >=1.
REQ-002 SHALL have parameter SIZE_B, default 8: matrix column count, >=1.
REQ-003 SHALL have parameter BITS, default 64: signed element width.
REQ-004 SHALL derive RW = max(1,$clog2(SIZE_A)), CW = max(1,$clog2(SIZE_B)), NW = $clog2(SIZE_A*SIZE_B+1).
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin a matrix load; sampled only in IDLE.
REQ-008 SHALL have port abort  input  1  cancel a load in progress; sampled only in LOAD.
REQ-009 SHALL have port in_valid  input  1  source presents an element.
REQ-010 SHALL have port in_data  input  BITS signed  element value, row-major order.
REQ-011 SHALL have port in_ready  output  1  controller accepts an element.
REQ-012 SHALL have port wr_en  output  1  write strobe to the matrix store.
REQ-013 SHALL have port wr_row  output  RW  write row index.
REQ-014 SHALL have port wr_col  output  CW  write column index.
REQ-015 SHALL have port wr_data  output  BITS signed  write value.
REQ-016 SHALL have port busy  output  1  high in LOAD.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the last element is written.
REQ-018 SHALL have port matrix_valid  output  1  high in FULL: complete matrix held.
REQ-019 SHALL have port release  input  1  consumer finished with the matrix; sampled only in FULL.
REQ-020 SHALL have port count  output  NW  elements accepted in current load.

Function
REQ-021 SHALL implement states IDLE, LOAD, FULL.
REQ-022 IDLE: in_ready=0; start=1 -> LOAD next cycle, row/col/count cleared to 0.
REQ-023 LOAD: in_ready=1 combinationally; busy=1; handshake = in_valid & in_ready.
REQ-024 On handshake SHALL register wr_en=1, wr_row=row, wr_col=col, wr_data=in_data, visible the next cycle (latency 1); wr_en=0 in every other cycle.
REQ-025 On handshake SHALL increment col; at col=SIZE_B-1 col wraps to 0 and row increments; count increments.
REQ-026 On handshake of element (SIZE_A-1,SIZE_B-1) SHALL enter FULL next cycle, with done=1 in that same cycle as its wr_en, and in_ready=0 from then on.
REQ-027 in_valid without handshake SHALL not change row, col, count or wr_* outputs.
REQ-028 abort=1 in LOAD SHALL go to IDLE next cycle, clear row/col/count, suppress any simultaneous handshake (no wr_en, no done); abort wins.
REQ-029 FULL: matrix_valid=1, in_ready=0, busy=0; count holds SIZE_A*SIZE_B.
REQ-030 release=1 in FULL -> IDLE next cycle; release=1 together with start=1 -> LOAD directly with counters cleared.
REQ-031 start in LOAD or FULL (without release), abort outside LOAD, release outside FULL SHALL be ignored.
REQ-032 SIZE_A=SIZE_B=1 SHALL complete on the first handshake.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, row=col=count=0, wr_en=0, wr_row=wr_col=0, wr_data=0, done=0, busy=0, matrix_valid=0, in_ready=0, regardless of clk.
REQ-034 rst asserted mid-load SHALL discard the partial load; no done pulse follows deassertion.
REQ-035 After rst deasserts, the block SHALL wait in IDLE for start.

Verification (SIZE_A=2, SIZE_B=3, BITS=16)
REQ-036 start, then 6 back-to-back valid words 1..6 -> wr_en on 6 consecutive cycles, (row,col) (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), data 1..6, done with the 6th, matrix_valid next cycle, count=6.
REQ-037 in_valid toggling 1,0,1,0... for 6 words -> same addresses/data as REQ-036, wr_en only after accepted words, count steps only on handshakes.
REQ-038 abort coincident with 3rd handshake -> only 2 wr_en, no done, IDLE next cycle, count=0; subsequent start reloads from (0,0).
REQ-039 rst pulsed after 4 words -> all outputs zero instantly; start then reloads 6 words from (0,0) with one done.
REQ-040 In FULL: start alone ignored; release+start in same cycle -> LOAD, in_ready=1, count=0; values -5 and 32767 appear unmodified on wr_data.

Source files
------------

// File: rtl/matrix_load_ctrl.sv
// Streams a SIZE_A x SIZE_B matrix in row-major order into a matrix store.
// Each accepted element becomes one registered write one cycle later. The matrix is then held until the consumer releases it.
module matrix_load_ctrl #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int BITS   = 64,
  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1,
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1,
  localparam int NW = $clog2(SIZE_A*SIZE_B+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic signed [BITS-1:0] in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [RW-1:0]          wr_row,
  output logic [CW-1:0]          wr_col,
  output logic signed [BITS-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   matrix_valid,
  input  logic                   matrix_release,
  output logic [NW-1:0]          count
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          hs, accept, last, clear;

  assign hs     = in_valid & in_ready;
  // abort has priority over a handshake in the same cycle
  assign accept = hs & ~abort;
  assign last   = (row == RW'(SIZE_A-1)) && (col == CW'(SIZE_B-1));
  assign clear  = ((state == IDLE) && start) ||
                  ((state == LOAD) && abort) ||
                  ((state == FULL) && matrix_release && start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort)              state_nxt = IDLE;
        else if (accept && last) state_nxt = FULL;
      end
      FULL: if (matrix_release) state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b0;
    matrix_valid = 1'b0;
    case (state)
      LOAD:    begin in_ready = 1'b1; busy = 1'b1; end
      FULL:    matrix_valid = 1'b1;
      default: ;
    endcase
  end

  // Write port and element counters; wr_* hold between accepted elements
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (clear) begin
        row   <= '0;
        col   <= '0;
        count <= '0;
      end else if (accept) begin
        wr_en   <= 1'b1;
        wr_row  <= row;
        wr_col  <= col;
        wr_data <= in_data;
        done    <= last;
        count   <= count + NW'(1);
        if (col == CW'(SIZE_B-1)) begin
          col <= '0;
          row <= last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Bench for matrix_load_ctrl (2x3, 16-bit): directed scenarios plus random traffic.
// A flat element-index model supplies every expected value.
module tb_matrix_load_ctrl;
  localparam int SA = 2, SB = 3, BW = 16, N = SA*SB;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, abort = 0, in_valid = 0, matrix_release = 0;
  logic signed [BW-1:0] in_data = '0;
  logic in_ready, wr_en, busy, done, matrix_valid;
  logic [0:0] wr_row;
  logic [1:0] wr_col;
  logic signed [BW-1:0] wr_data;
  logic [2:0] count;

  int checks = 0, errors = 0;

  // model: number of accepted elements, loading / full flags, expected write port
  int  m_k = 0;
  bit  m_load = 0, m_full = 0;
  bit  e_wr_en = 0, e_done = 0;
  int  e_row = 0, e_col = 0;
  logic signed [BW-1:0] e_data = '0;

  matrix_load_ctrl #(.SIZE_A(SA), .SIZE_B(SB), .BITS(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .done(done), .matrix_valid(matrix_valid),
    .matrix_release(matrix_release), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("wr_en", wr_en, e_wr_en);
    chk("done", done, e_done);
    chk("wr_row", wr_row, e_row);
    chk("wr_col", wr_col, e_col);
    chk("wr_data", wr_data, e_data);
    chk("count", count, m_k);
    chk("busy", busy, m_load);
    chk("matrix_valid", matrix_valid, m_full);
    chk("in_ready", in_ready, m_load);
  endtask

  // Async reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    m_k = 0; m_load = 0; m_full = 0;
    e_wr_en = 0; e_done = 0; e_row = 0; e_col = 0; e_data = '0;
    #1 chk_all();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Apply one cycle of inputs, predict the outcome, check after the edge
  task automatic tick(input bit s, input bit a, input bit v, input logic signed [BW-1:0] d, input bit r);
    start = s; abort = a; in_valid = v; in_data = d; matrix_release = r;
    #1 chk("in_ready_pre", in_ready, m_load);
    e_wr_en = 0; e_done = 0;
    if (m_load) begin
      if (a) begin
        m_load = 0; m_k = 0;
      end else if (v) begin
        e_wr_en = 1; e_row = m_k / SB; e_col = m_k % SB; e_data = d;
        m_k++;
        if (m_k == N) begin e_done = 1; m_load = 0; m_full = 1; end
      end
    end else if (m_full) begin
      if (r) begin
        m_full = 0;
        if (s) begin m_load = 1; m_k = 0; end
      end
    end else if (s) begin
      m_load = 1; m_k = 0;
    end
    @(posedge clk); #1;
    chk_all();
  endtask

  task automatic idle();
    tick(0, 0, 0, '0, 0);
  endtask

  initial begin
    logic signed [BW-1:0] d;
    int dones;
    #2 chk_all();
    @(posedge clk); #1 rst = 1'b0;
    idle();

    // back-to-back load of 1..6
    tick(1, 0, 0, '0, 0);
    for (int i = 1; i <= N; i++) tick(0, 0, 1, BW'(i), 0);
    idle();
    idle();
    // start alone in FULL is ignored, then release returns to idle
    tick(1, 0, 0, '0, 0);
    tick(0, 0, 0, '0, 1);
    idle();

    // alternating valid
    tick(1, 0, 0, '0, 0);
    for (int i = 1; i <= N; i++) begin
      tick(0, 0, 1, BW'(i*11), 0);
      tick(0, 0, 0, BW'(99), 0);
    end
    // release with start goes straight back to LOAD
    tick(1, 0, 0, '0, 1);
    chk("in_ready_relstart", in_ready, 1'b1);
    chk("count_relstart", count, 3'd0);
    tick(0, 0, 1, -16'sd5, 0);
    tick(0, 0, 1, 16'sd32767, 0);
    // abort together with the 3rd handshake
    tick(0, 1, 1, 16'sd77, 0);
    idle();
    tick(0, 1, 0, '0, 0);
    tick(1, 0, 0, '0, 0);
    for (int i = 1; i <= 4; i++) tick(0, 0, 1, BW'(i + 40), 0);
    do_reset();
    idle();
    // reload after reset yields exactly one done
    tick(1, 0, 0, '0, 0);
    dones = 0;
    for (int i = 1; i <= N; i++) begin
      tick(0, 0, 1, BW'(i), 0);
      if (done) dones++;
    end
    chk("single_done", dones, 1);
    tick(0, 0, 0, '0, 1);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        d = BW'($urandom);
        tick($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
